seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB-first.
// IDLE accepts a start, RUN iterates WIDTH times, DONE pulses for one cycle with results.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd, dvs, qacc;
  logic [WIDTH-1:0] pr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial, inv, pr_nx, q_nx;
  logic             carry, qbit;

  // Valid/ready: a request is taken when start=1 at a rising edge while IDLE;
  // busy marks RUN and done is the one-cycle result-valid strobe.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign inv  = ~dvs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Trial subtraction as a ripple adder of the inverted divisor with carry-in 1.
  // The top stage sees an inverted zero, so its carry-out reduces to an OR.
  always_comb begin
    shifted = {pr, dvd[WIDTH-1]};
    trial   = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      trial[i] = shifted[i] ^ inv[i] ^ carry;
      carry    = (shifted[i] & inv[i]) | (carry & (shifted[i] ^ inv[i]));
    end
    qbit  = shifted[WIDTH] | carry;
    pr_nx = qbit ? trial : shifted[WIDTH-1:0];
    q_nx  = {qacc[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      qacc        <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd         <= dividend;
          dvs         <= divisor;
          qacc        <= '0;
          pr          <= '0;
          cnt         <= '0;
          div_by_zero <= (divisor == '0);
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
          end
        end
        RUN: begin
          pr   <= pr_nx;
          qacc <= q_nx;
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          // Results become visible only on the final step.
          if (cnt == LAST) begin
            quotient  <= q_nx;
            remainder <= pr_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=4): directed cases, reset abort, and a full
// operand sweep with start held high, checked against an arithmetic model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q_hold = '0;
  logic [W-1:0] exp_r_hold = '0;
  logic         exp_dbz_hold = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One division from IDLE; optionally keep start high and scramble operands
  // while the divider works. Returns in IDLE one cycle after done.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold_start, input bit scramble);
    logic [W-1:0] eq, er;
    int cyc;
    eq = (b == 0) ? {W{1'b1}} : W'(a / b);
    er = (b == 0) ? a : W'(a % b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      check("busy_in_run", busy, 1);
      check("q_hold", quotient, exp_q_hold);
      check("r_hold", remainder, exp_r_hold);
      if (scramble) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      step();
      cyc++;
    end
    check("latency", cyc, (b == 0) ? 0 : W);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", div_by_zero, (b == 0));
    check("busy_at_done", busy, 0);
    exp_q_hold = eq;
    exp_r_hold = er;
    exp_dbz_hold = (b == 0);
    step();
    check("done_pulse_len", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    step();
    step();
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // Directed cases; the first start is taken on the first edge after release.
    run_one(4'd13, 4'd4, 0, 0);
    run_one(4'd15, 4'd1, 0, 0);
    run_one(4'd3,  4'd9, 0, 0);
    run_one(4'd0,  4'd5, 0, 0);
    run_one(4'd7,  4'd0, 0, 0);
    run_one(4'd8,  4'd2, 0, 0);

    // start stays high during RUN/DONE with changing operands: ignored.
    run_one(4'd12, 4'd5, 1, 1);
    start = 1'b0;
    step();
    check("idle_after_hold", busy | done, 0);

    // Abort mid-RUN with an asynchronous reset after E2.
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", div_by_zero, 0);
    step();
    rst = 1'b0;
    exp_q_hold = '0;
    exp_r_hold = '0;
    for (int k = 0; k < 8; k++) begin
      check("no_done_after_abort", done | busy, 0);
      step();
    end
    run_one(4'd9, 4'd2, 0, 0);

    // Full sweep, back-to-back with start held, operands scrambled during work.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_one(W'(a), W'(b), 1, ($urandom_range(0, 1) == 1));
      end
    end
    start = 1'b0;
    step();
    check("final_idle", busy | done, 0);
    check("final_dbz", div_by_zero, exp_dbz_hold);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
